// File: rtl/vector_issue_pkg.sv
// vector_issue_pkg: shared constants and types for the vector instruction issue path.
// Rev 1.0
`default_nettype none

package vector_issue_pkg;
  localparam int unsigned VIQ_DEPTH  = 8;
  localparam int unsigned VIQ_DATA_W = 96;

  typedef logic [VIQ_DATA_W-1:0] viq_instr_t;

  // Pointer width for a power-of-two depth; a depth of 1 still needs one bit.
  function automatic int unsigned viq_ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  localparam int unsigned VIQ_PTR_W = viq_ptr_w(VIQ_DEPTH);
endpackage

`default_nettype wire

// File: rtl/viq_storage.sv
// viq_storage: DEPTH x WIDTH register array, one write port, one asynchronous read port.
// Rev 1.0
`default_nettype none

module viq_storage
  import vector_issue_pkg::*;
#(
  parameter int unsigned WIDTH = VIQ_DATA_W,
  parameter int unsigned DEPTH = VIQ_DEPTH,
  parameter int unsigned PTR_W = viq_ptr_w(DEPTH)
)(
  input  logic             clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

`default_nettype wire

// File: rtl/vector_instr_queue.sv
// vector_instr_queue: circular instruction FIFO between scalar core and vector dispatch.
// Define VIQ_BYPASS_EN for same-cycle empty-queue bypass. Rev 1.0
`default_nettype none

module vector_instr_queue
  import vector_issue_pkg::*;
#(
  parameter int unsigned DATA_FROM_SCALAR = $bits(viq_instr_t),
  parameter int unsigned DEPTH            = VIQ_DEPTH
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_valid,
  input  logic [DATA_FROM_SCALAR-1:0]   push_data,
  output logic                          push_ready,
  input  logic                          flush,
  output logic [DATA_FROM_SCALAR-1:0]   instruction,
  output logic                          valid_fifo,
  input  logic                          ready,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          empty
);
  localparam int unsigned PTR_W = viq_ptr_w(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]            r_wptr;
  logic [PTR_W-1:0]            r_rptr;
  logic [CNT_W-1:0]            r_count;
  logic [DATA_FROM_SCALAR-1:0] w_rdata;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_bypass;
  logic                        w_valid;
  logic                        w_push_fire;
  logic                        w_pop_fire;
  logic                        w_wr_en;
  logic                        w_rd_adv;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

`ifdef VIQ_BYPASS_EN
  assign w_bypass = w_empty && push_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_valid     = !w_empty || w_bypass;
  assign push_ready  = !w_full && !flush;
  assign w_push_fire = push_valid && push_ready;
  assign w_pop_fire  = w_valid && ready;
  // A bypassed word consumed in the same cycle never touches storage.
  assign w_wr_en     = w_push_fire && !(w_bypass && ready);
  assign w_rd_adv    = w_pop_fire && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_en) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_rd_adv) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_wr_en, w_rd_adv})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  viq_storage #(
    .WIDTH (DATA_FROM_SCALAR),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wptr),
    .i_wdata (push_data),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  assign valid_fifo  = w_valid;
  assign instruction = !w_valid ? '0 : (w_bypass ? push_data : w_rdata);
  assign count       = r_count;
  assign full        = w_full;
  assign empty       = w_empty;
endmodule

`default_nettype wire

// File: doc/vector_instr_queue.md
VECTOR_INSTR_QUEUE -- requirements
Module: vector_instr_queue

Interface
REQ-001 SHALL have parameter DATA_FROM_SCALAR, default 96, width of one issued instruction word from the scalar core.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; must be a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port push_valid, input, 1, scalar core offers an instruction.
REQ-006 SHALL have port push_data, input, DATA_FROM_SCALAR, instruction word from the scalar core.
REQ-007 SHALL have port push_ready, output, 1, queue can accept a word this cycle.
REQ-008 SHALL have port flush, input, 1, discards all queued entries.
REQ-009 SHALL have port instruction, output, DATA_FROM_SCALAR, head word presented to the dispatch unit.
REQ-010 SHALL have port valid_fifo, output, 1, the instruction port holds a valid head word.
REQ-011 SHALL have port ready, input, 1, dispatch consumes the head word this cycle.
REQ-012 SHALL have port count, output, $clog2(DEPTH+1), number of occupied entries.
REQ-013 SHALL have ports full and empty, output, 1 each, occupancy flags.

Function
REQ-014 SHALL accept a push when push_valid and push_ready are both high at a rising edge.
REQ-015 SHALL pop the head when valid_fifo and ready are both high at a rising edge; ready with valid_fifo low has no effect.
REQ-016 SHALL drive push_ready = !full && !flush, with no combinational path from ready.
REQ-017 SHALL drive valid_fifo = !empty, plus the bypass case of REQ-028.
REQ-018 SHALL hold instruction stable while valid_fifo is high and ready is low.
REQ-019 SHALL drive instruction to all zeros whenever valid_fifo is low.
REQ-020 SHALL store entries in a circular buffer with log2(DEPTH)-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-021 SHALL track occupancy with a count register: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-022 SHALL allow a simultaneous push and pop when full; push_ready is low in that case, so no push occurs and count becomes DEPTH-1.
REQ-023 SHALL allow a simultaneous push and pop with count=1; the new word becomes head next cycle and count stays 1.
REQ-024 SHALL give flush priority over push and pop: pointers and count go to 0, and any same-cycle push or pop is discarded.
REQ-025 SHALL produce full = (count==DEPTH) and empty = (count==0), both derived from registered state.
REQ-026 SHALL have a latency of one cycle from an accepted push into an empty queue to valid_fifo high, when bypass is not compiled in.

Reset
REQ-027 SHALL, on a clock edge with rst high: set pointers=0, count=0, empty=1, full=0, valid_fifo=0, instruction=0, and push_ready=1 from the next cycle; storage contents are not reset; rst has priority over flush, push and pop.

Configuration
REQ-028 SHALL, with macro VIQ_BYPASS_EN defined, present push_data on instruction with valid_fifo=1 in the same cycle when empty and push_valid are high; if ready is also high, the word is consumed without being written and count stays 0.
REQ-029 SHALL, without VIQ_BYPASS_EN, have no combinational path from push_* to instruction or valid_fifo.

Structure
REQ-030 SHALL take the DEPTH default, the pointer-width constant and the instruction word typedef from shared package vector_issue_pkg.
REQ-031 SHALL instantiate one sub-module, viq_storage: a DEPTH x DATA_FROM_SCALAR register array with one write port and one asynchronous read port.

Verification (DEPTH=8)
REQ-032 SHALL cover: reset, then push 0xA1 with ready=0 -> next cycle valid_fifo=1, instruction=0xA1, count=1.
REQ-033 SHALL cover: push 8 words 0x01..0x08 with ready=0 -> full=1, push_ready=0; 9th push 0x09 is rejected; pops return 0x01..0x08 in order.
REQ-034 SHALL cover: 20 cycles of continuous push and pop (wrap-around) -> count stays 1 and no word is lost or duplicated.
REQ-035 SHALL cover: count=5 with flush, push_valid and ready all high -> next cycle count=0, valid_fifo=0, instruction=0.
REQ-036 SHALL cover: VIQ_BYPASS_EN defined, empty queue, push 0x55 with ready=1 -> same-cycle valid_fifo=1, instruction=0x55, count stays 0.
REQ-037 SHALL cover: rst asserted at count=3 -> next cycle count=0, empty=1, push_ready=1.
